// File: rtl/pcie_sw_pkg.sv
// Shared switch definitions: default sizes, arbiter FSM encoding and the
// destination-field helper used by the ingress and egress arbiters.
package pcie_sw_pkg;

  localparam int DATA_SIZE_DEF = 10;
  localparam int NUM_IN_DEF    = 4;
  localparam int DEST_W_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic logic [DEST_W_DEF-1:0] dest_of(input logic [DATA_SIZE_DEF-1:0] word);
    return word[DATA_SIZE_DEF-1 -: DEST_W_DEF];
  endfunction

endpackage

// File: rtl/pcie_rr_arbiter_rr_grant.sv
// Combinational round-robin grant: picks the first requester strictly after
// the pointer in ascending modulo-N order; returns a one-hot (or zero) grant.
module rr_grant #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  // Walk the requesters starting one past the pointer, first hit wins.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx] && !found) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/pcie_rr_arbiter.sv
// Round-robin ingress-to-egress arbiter: pops ingress FIFOs, routes each word
// by its destination field. Optional per-input grant counters: ARB_STATS_EN.
module pcie_rr_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int NUM_IN    = 4,
  parameter int DEST_W    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           fifo_empty_in,
  input  logic [NUM_IN-1:0]           almost_empty_in,
  input  logic [NUM_IN*DATA_SIZE-1:0] data_out_pop_in,
  output logic [NUM_IN-1:0]           read_out,
  input  logic [(2**DEST_W)-1:0]      pause_in,
  output logic [(2**DEST_W)-1:0]      write_out,
  output logic [DATA_SIZE-1:0]        data_in_push_out,
  output logic                        idle
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_IN*8-1:0]         grant_count
`endif
);
  import pcie_sw_pkg::*;

  localparam int NUM_OUT = 2 ** DEST_W;
  localparam int PW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  arb_state_e           state_r;
  logic [NUM_IN-1:0]    read_r, rd_prev_r, req_s, gnt_s;
  logic [NUM_OUT-1:0]   write_r;
  logic [DATA_SIZE-1:0] push_data_r, word_s;
  logic [PW-1:0]        ptr_r, gnt_idx_s;
  logic                 any_pause_s, all_empty_s, pipe_empty_s;

  assign any_pause_s  = |pause_in;
  assign all_empty_s  = &fifo_empty_in;
  assign pipe_empty_s = ~|read_r && ~|rd_prev_r && ~|write_r;

  // Flags lag a pop by one cycle, so an input read this cycle with <=1 word left must sit out.
  always_comb begin
    if (state_r == RUN && !any_pause_s) begin
      req_s = ~fifo_empty_in & ~(read_r & almost_empty_in);
    end else begin
      req_s = '0;
    end
  end

  rr_grant #(.N(NUM_IN)) u_grant (
    .req (req_s),
    .ptr (ptr_r),
    .gnt (gnt_s)
  );

  // Encode the grant for the pointer and select the slice popped last cycle.
  always_comb begin
    gnt_idx_s = ptr_r;
    word_s    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_s[i]) begin
        gnt_idx_s = PW'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
      if (rd_prev_r[i]) begin
        word_s = word_s | data_out_pop_in[i*DATA_SIZE +: DATA_SIZE];
      end else begin
        word_s = word_s;
      end
    end
  end

  // Arbiter FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    if (!all_empty_s && !any_pause_s) state_r <= RUN;
        RUN:     if (any_pause_s) state_r <= DRAIN;
                 else if (all_empty_s && pipe_empty_s) state_r <= IDLE;
        DRAIN:   if (!any_pause_s) state_r <= (all_empty_s && pipe_empty_s) ? IDLE : RUN;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Read strobe, capture stage and egress push register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_r      <= '0;
      rd_prev_r   <= '0;
      write_r     <= '0;
      push_data_r <= '0;
      ptr_r       <= PW'(NUM_IN - 1);
    end else begin
      read_r    <= gnt_s;
      rd_prev_r <= read_r;
      ptr_r     <= gnt_idx_s;
      if (|rd_prev_r) begin
        write_r     <= {{(NUM_OUT-1){1'b0}}, 1'b1} << dest_of(word_s);
        push_data_r <= word_s;
      end else begin
        write_r     <= '0;
        push_data_r <= push_data_r;
      end
    end
  end

  assign read_out         = read_r;
  assign write_out        = write_r;
  assign data_in_push_out = push_data_r;
  assign idle             = (state_r == IDLE) && ~|rd_prev_r && ~|write_r;

`ifdef ARB_STATS_EN
  logic [NUM_IN*8-1:0] count_r;

  // Per-input grant counters, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (read_r[i] && count_r[i*8 +: 8] != 8'hFF) begin
          count_r[i*8 +: 8] <= count_r[i*8 +: 8] + 8'd1;
        end else begin
          count_r[i*8 +: 8] <= count_r[i*8 +: 8];
        end
      end
    end
  end

  assign grant_count = count_r;
`endif

endmodule

// File: tb/tb_pcie_rr_arbiter.sv
// Self-checking bench for pcie_rr_arbiter: behavioural ingress FIFOs, a
// read/write monitor and an expected-word scoreboard. Stats checks need ARB_STATS_EN.
module tb_pcie_rr_arbiter;
  localparam int DS = 10;
  localparam int NI = 4;
  localparam int NO = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NI-1:0]  fifo_empty = '1;
  logic [NI-1:0]  almost_empty = '1;
  logic [NI*DS-1:0] pop_data = '0;
  logic [NI-1:0]  read_out;
  logic [NO-1:0]  pause = '0;
  logic [NO-1:0]  write_out;
  logic [DS-1:0]  push_data;
  logic           idle;
`ifdef ARB_STATS_EN
  logic [NI*8-1:0] grant_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int underflow = 0;

  logic [DS-1:0] fq [NI][$];
  logic [DS-1:0] exp_q [$];
  logic [NI-1:0] rd_vec_q [$];
  int            rd_cyc_q [$];
  logic [NO-1:0] wr_vec_q [$];
  logic [DS-1:0] wr_dat_q [$];
  int            wr_cyc_q [$];

  pcie_rr_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_empty_in    (fifo_empty),
    .almost_empty_in  (almost_empty),
    .data_out_pop_in  (pop_data),
    .read_out         (read_out),
    .pause_in         (pause),
    .write_out        (write_out),
    .data_in_push_out (push_data),
    .idle             (idle)
`ifdef ARB_STATS_EN
    ,
    .grant_count      (grant_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ingress FIFO model: registered pop data, flags updated the cycle after a read.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (read_out[i] && reset) begin
        if (fq[i].size() == 0) underflow <= underflow + 1;
        else pop_data[i*DS +: DS] <= fq[i].pop_front();
      end
      fifo_empty[i]   <= (fq[i].size() == 0);
      almost_empty[i] <= (fq[i].size() <= 1);
    end
  end

  // Monitor: log every read and write strobe with its cycle number.
  always @(negedge clk) begin
    if (read_out != '0) begin
      rd_vec_q.push_back(read_out);
      rd_cyc_q.push_back(cyc);
    end
    if (write_out != '0) begin
      wr_vec_q.push_back(write_out);
      wr_dat_q.push_back(push_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rd_vec_q.delete(); rd_cyc_q.delete();
    wr_vec_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    exp_q.delete();
    underflow = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pause = '0;
    for (int i = 0; i < NI; i++) fq[i].delete();
    step(2);
    reset = 1'b1;
    step(1);
    clear_logs();
  endtask

  task automatic load(input int i, input logic [DS-1:0] w);
    fq[i].push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      step(1);
      if (idle === 1'b1 && wr_vec_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    n_cmp++; if (read_out !== 4'b0000) begin n_bad++; $display("FAIL reset_read: got %b expected 0000", read_out); end
    n_cmp++; if (write_out !== 4'b0000) begin n_bad++; $display("FAIL reset_write: got %b expected 0000", write_out); end
    n_cmp++; if (push_data !== 10'h000) begin n_bad++; $display("FAIL reset_data: got %h expected 000", push_data); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b expected 1", idle); end
    reset = 1'b1;
    step(3);
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle: got %b expected 1", idle); end
  endtask

  task automatic test_single_input();
    bit ok;
    logic [NO-1:0] ev;
    logic [DS-1:0] e;
    do_reset();
    load(0, 10'h005); load(0, 10'h1AA); load(0, 10'h2FF); load(0, 10'h300);
    wait_idle(4, 60, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b expected 1", ok); end
    n_cmp++; if (rd_vec_q.size() != 4) begin n_bad++; $display("FAIL single_reads: got %0d expected 4", rd_vec_q.size()); end
    n_cmp++; if (underflow != 0) begin n_bad++; $display("FAIL single_underflow: got %0d expected 0", underflow); end
    for (int k = 0; k < 4 && k < rd_vec_q.size() && k < wr_vec_q.size(); k++) begin
      e  = exp_q[k];
      ev = 4'b0001 << e[9:8];
      n_cmp++; if (rd_vec_q[k] !== 4'b0001 || rd_cyc_q[k] != rd_cyc_q[0] + k) begin
        n_bad++; $display("FAIL single_read%0d: got %b@%0d expected 0001@%0d", k, rd_vec_q[k], rd_cyc_q[k], rd_cyc_q[0] + k); end
      n_cmp++; if (wr_vec_q[k] !== ev || wr_dat_q[k] !== e) begin
        n_bad++; $display("FAIL single_push%0d: got %b/%h expected %b/%h", k, wr_vec_q[k], wr_dat_q[k], ev, e); end
      n_cmp++; if (wr_cyc_q[k] != rd_cyc_q[0] + 2 + k) begin
        n_bad++; $display("FAIL single_latency%0d: got cycle %0d expected %0d", k, wr_cyc_q[k], rd_cyc_q[0] + 2 + k); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [NO-1:0] ev;
    logic [DS-1:0] e;
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NI; i++)
        load(i, DS'((((i + 3 * j) % 4) << 8) | (16 * j + i + 1)));
    wait_idle(8, 80, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rr_done: got %b expected 1", ok); end
    n_cmp++; if (wr_vec_q.size() != 8) begin n_bad++; $display("FAIL rr_pushes: got %0d expected 8", wr_vec_q.size()); end
    n_cmp++; if (underflow != 0) begin n_bad++; $display("FAIL rr_underflow: got %0d expected 0", underflow); end
    for (int k = 0; k < 8 && k < rd_vec_q.size() && k < wr_vec_q.size(); k++) begin
      e  = exp_q[k];
      ev = 4'b0001 << e[9:8];
      n_cmp++; if (rd_vec_q[k] !== (4'b0001 << (k % 4))) begin
        n_bad++; $display("FAIL rr_order%0d: got %b expected %b", k, rd_vec_q[k], 4'b0001 << (k % 4)); end
      n_cmp++; if (wr_vec_q[k] !== ev || wr_dat_q[k] !== e) begin
        n_bad++; $display("FAIL rr_push%0d: got %b/%h expected %b/%h", k, wr_vec_q[k], wr_dat_q[k], ev, e); end
    end
`ifdef ARB_STATS_EN
    for (int i = 0; i < NI; i++) begin
      n_cmp++; if (grant_count[i*8 +: 8] !== 8'd2) begin
        n_bad++; $display("FAIL rr_count%0d: got %0d expected 2", i, grant_count[i*8 +: 8]); end
    end
`endif
  endtask

  task automatic test_pause();
    bit ok;
    bit seen;
    int pcyc;
    int rd_after;
    int wr_after;
    logic [NO-1:0] ev;
    logic [DS-1:0] e;
    do_reset();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < NI; i++)
        load(i, DS'((((i + j) % 4) << 8) | (32 * j + 4 * i + 3)));
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      seen = (rd_vec_q.size() >= 3);
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL pause_start: got %b expected 1", seen); end
    pcyc = cyc;
    pause = 4'b0100;
    step(10);
    rd_after = 0;
    wr_after = 0;
    foreach (rd_cyc_q[k]) if (rd_cyc_q[k] > pcyc) rd_after++;
    foreach (wr_cyc_q[k]) if (wr_cyc_q[k] > pcyc) wr_after++;
    n_cmp++; if (rd_after != 0) begin n_bad++; $display("FAIL pause_reads: got %0d expected 0", rd_after); end
    n_cmp++; if (wr_after != 2) begin n_bad++; $display("FAIL pause_inflight: got %0d expected 2", wr_after); end
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL pause_idle: got %b expected 0", idle); end
    pause = 4'b0000;
    wait_idle(12, 100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL pause_done: got %b expected 1", ok); end
    n_cmp++; if (underflow != 0) begin n_bad++; $display("FAIL pause_underflow: got %0d expected 0", underflow); end
    for (int k = 0; k < 12 && k < rd_vec_q.size() && k < wr_vec_q.size(); k++) begin
      e  = exp_q[k];
      ev = 4'b0001 << e[9:8];
      n_cmp++; if (rd_vec_q[k] !== (4'b0001 << (k % 4))) begin
        n_bad++; $display("FAIL pause_order%0d: got %b expected %b", k, rd_vec_q[k], 4'b0001 << (k % 4)); end
      n_cmp++; if (wr_vec_q[k] !== ev || wr_dat_q[k] !== e) begin
        n_bad++; $display("FAIL pause_push%0d: got %b/%h expected %b/%h", k, wr_vec_q[k], wr_dat_q[k], ev, e); end
    end
  endtask

  task automatic test_last_word();
    logic [DS-1:0] e;
    do_reset();
    load(1, 10'h2C3);
    step(12);
    e = exp_q[0];
    n_cmp++; if (rd_vec_q.size() != 1) begin n_bad++; $display("FAIL last_reads: got %0d expected 1", rd_vec_q.size()); end
    n_cmp++; if (underflow != 0) begin n_bad++; $display("FAIL last_underflow: got %0d expected 0", underflow); end
    n_cmp++; if (wr_vec_q.size() != 1 || wr_vec_q[0] !== 4'b0100 || wr_dat_q[0] !== e) begin
      n_bad++; $display("FAIL last_push: got %0d pushes expected one %h to 0100", wr_vec_q.size(), e); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL last_idle: got %b expected 1", idle); end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    bit ok;
    do_reset();
    load(0, 10'h011); load(0, 10'h122); load(0, 10'h233); load(0, 10'h344);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      seen = (wr_vec_q.size() >= 1);
    end
    n_cmp++; if (seen !== 1'b1 || read_out !== 4'b0001 || write_out !== 4'b0001) begin
      n_bad++; $display("FAIL midflight_pre: got %b/%b/%b expected 1/0001/0001", seen, read_out, write_out); end
    reset = 1'b0;
    #1;
    n_cmp++; if (read_out !== 4'b0000) begin n_bad++; $display("FAIL async_read: got %b expected 0000", read_out); end
    n_cmp++; if (write_out !== 4'b0000) begin n_bad++; $display("FAIL async_write: got %b expected 0000", write_out); end
    for (int i = 0; i < NI; i++) fq[i].delete();
    step(2);
    reset = 1'b1;
    step(1);
    clear_logs();
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL midflight_idle: got %b expected 1", idle); end
    load(0, 10'h0A5);
    load(3, 10'h35A);
    wait_idle(2, 40, ok);
    n_cmp++; if (ok !== 1'b1 || rd_vec_q.size() != 2) begin
      n_bad++; $display("FAIL midflight_done: got %b/%0d expected 1/2", ok, rd_vec_q.size()); end
    n_cmp++; if (rd_vec_q.size() < 1 || rd_vec_q[0] !== 4'b0001) begin
      n_bad++; $display("FAIL first_grant: got %b expected 0001", rd_vec_q.size() > 0 ? rd_vec_q[0] : 4'b0000); end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats_saturate();
    bit ok;
    do_reset();
    for (int k = 0; k < 300; k++) load(3, DS'(k));
    wait_idle(300, 1000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %b expected 1", ok); end
    n_cmp++; if (grant_count[24 +: 8] !== 8'd255) begin
      n_bad++; $display("FAIL sat_count3: got %0d expected 255", grant_count[24 +: 8]); end
    n_cmp++; if (grant_count[0 +: 24] !== 24'd0) begin
      n_bad++; $display("FAIL sat_others: got %h expected 000000", grant_count[0 +: 24]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_input();
    test_round_robin();
    test_pause();
    test_last_word();
    test_reset_midflight();
`ifdef ARB_STATS_EN
    test_stats_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/pcie_rr_arbiter.md
Name: pcie_rr_arbiter

Overview:
- Downstream consumer of the ingress FIFO bank. Pops words from NUM_IN ingress FIFOs in round-robin order.
- Routes each word to one of 4 egress FIFOs, selected by the destination field in its top DEST_W bits.
- Honours egress fifo_pause back-pressure and never pops an empty FIFO.
- Sits between the per-port ingress FIFOs and the per-port egress FIFOs of the switch.

Parameters:
- DATA_SIZE, 10: word width; bits [DATA_SIZE-1 -: DEST_W] are the destination and the rest are payload.
- NUM_IN, 4: number of ingress FIFOs arbitrated.
- DEST_W, 2: destination field width; the number of egress FIFOs is 2**DEST_W = 4.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low; the block is in reset while reset==0.
- fifo_empty_in  in  NUM_IN  empty flags of the ingress FIFOs.
- almost_empty_in  in  NUM_IN  almost_empty flags of the ingress FIFOs (asserted at <=1 word).
- data_out_pop_in  in  NUM_IN*DATA_SIZE  packed ingress pop data; input i occupies slice [i*DATA_SIZE +: DATA_SIZE].
- read_out  out  NUM_IN  read strobes to the ingress FIFOs; one-hot or zero.
- pause_in  in  4  fifo_pause flags of the egress FIFOs.
- write_out  out  4  write strobes to the egress FIFOs; one-hot or zero.
- data_in_push_out  out  DATA_SIZE  word presented to the egress FIFOs.
- idle  out  1  high when no word is in flight and all inputs are empty.

Behaviour:
- Reset values: read_out=0, write_out=0, data_in_push_out=0, idle=1, rr pointer=NUM_IN-1 (so input 0 wins first), state=IDLE. All pipeline valids are cleared.
- Ingress FIFO contract: data_out_pop is registered and valid in the cycle after read is asserted. The empty and almost_empty flags also update in that cycle.
- Pipeline:
  - Cycle N: grant and assert read_out[g].
  - Cycle N+1: capture data_out_pop_in slice g into the stage-2 register.
  - Cycle N+2: write_out[dest]=1 and data_in_push_out=word.
  - Pop-to-push latency is 2 cycles. Throughput is 1 word/cycle.
- Eligibility of input i in cycle N, all conditions required:
  - fifo_empty_in[i]==0;
  - if i was granted in N-1, almost_empty_in[i] must also be 0 (prevents popping the last word twice);
  - state==RUN.
- Grant rule: the first eligible input strictly after the rr pointer, in ascending modulo-NUM_IN order. The pointer updates to g only when a grant is issued. If nothing is eligible, read_out=0.
- Back-pressure:
  - Any pause_in bit high stops new grants in that cycle, regardless of destination. This is the conservative head-of-line policy.
  - Words already in flight (at most 2) still complete their push.
  - Egress almost_full thresholds must leave >=2 free entries.
- FSM:
  - IDLE -> RUN when any fifo_empty_in bit is 0 and pause_in==0.
  - RUN -> DRAIN when |pause_in is high.
  - RUN -> IDLE when all inputs are empty and the pipeline is empty.
  - DRAIN -> RUN when pause_in==0.
  - DRAIN -> IDLE when pause_in==0, all inputs are empty and the pipeline is empty.
  - No grants are issued in IDLE or DRAIN.
- idle=1 exactly when state==IDLE and both pipeline valids are 0.
- Reset asserted mid-operation: all strobes drop immediately (asynchronous) and in-flight words are discarded. The upstream FIFO reset owns the consistency of the discarded data.
- Simultaneous events: a push and a new grant in the same cycle are independent. When pause rises in the same cycle a grant would occur, pause wins.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds output grant_count (NUM_IN*8 bits): one 8-bit counter per input, saturating at 255 and cleared by reset. Counter i increments on each cycle where read_out[i]==1.
- When undefined, the port and the counters are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Shared package pcie_sw_pkg holds:
  - DATA_SIZE, DEST_W and NUM_IN defaults;
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - a dest-field extraction function.
- One natural sub-module: rr_grant. It is combinational: NUM_IN request vector plus pointer in, one-hot grant out. It is reusable by the egress side.

Test Plan:
1. Only input 0 loaded with words 0x005, 0x1AA, 0x2FF, 0x300 -> pops are back-to-back. Output is write_out = 0001, 0010, 0100, 1000 on consecutive cycles, starting 2 cycles after the first read, with matching data.
2. All 4 inputs hold 2 words each -> read_out order is 0,1,2,3,0,1,2,3. No input is read while empty. 8 pushes occur in total.
3. pause_in[2] rises mid-stream -> read_out=0 from that cycle on. Exactly the <=2 in-flight words are still pushed. After pause falls, arbitration resumes at the input following the last grant.
4. Input 1 holds exactly 1 word (almost_empty=1) and is the only request -> a single read, with no second read in the following cycle, then FSM returns to IDLE and idle=1.
5. reset driven low while 2 words are in flight -> read_out and write_out go to 0 asynchronously. After release, idle=1 and the first grant goes to input 0.
6. With ARB_STATS_EN defined, scenario 2 gives grant_count of 2 for each input. A 300-word stream on input 3 saturates its counter at 255.
